// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl
//   Writeback controller for the integer register file's single write port.
//   Merges ALU results (valid/ready) with LSU load responses (valid only),
//   aligns and extends load data, and keeps a per-register pending-load mask
//   for decode.
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_alu_valid      ALU result valid
//   o_alu_ready      ALU result accepted when valid & ready (= !buf_valid)
//   i_alu_rd         ALU destination register
//   i_alu_data       ALU result
//   i_ld_valid       load response valid (always accepted)
//   i_ld_rd          load destination register
//   i_ld_raw         raw aligned memory word
//   i_ld_funct3      RV32I load funct3
//   i_ld_addr_lo     byte address bits [1:0]
//   i_ld_issue       decode issued a load this cycle
//   i_ld_issue_rd    destination of the issued load
//   o_rd_addr        regfile write address
//   o_rd_wren        regfile write enable (one-cycle pulse per write)
//   o_rd_data        regfile write data
//   o_busy           per-register pending-load mask (bit 0 always 0)
//   o_ld_err         one-cycle pulse on illegal or misaligned load response
module regfile_wb_ctrl #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_alu_valid,
    output logic                 o_alu_ready,
    input  logic [AW-1:0]        i_alu_rd,
    input  logic [XLEN-1:0]      i_alu_data,
    input  logic                 i_ld_valid,
    input  logic [AW-1:0]        i_ld_rd,
    input  logic [XLEN-1:0]      i_ld_raw,
    input  logic [2:0]           i_ld_funct3,
    input  logic [1:0]           i_ld_addr_lo,
    input  logic                 i_ld_issue,
    input  logic [AW-1:0]        i_ld_issue_rd,
    output logic [AW-1:0]        o_rd_addr,
    output logic                 o_rd_wren,
    output logic [XLEN-1:0]      o_rd_data,
    output logic [(1<<AW)-1:0]   o_busy,
    output logic                 o_ld_err
);

    localparam int NREG = 1 << AW;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_LD,
        SRC_BUF,
        SRC_ALU
    } src_e;

    // One-entry holding buffer for an ALU result that lost to a load
    logic            buf_valid;
    logic [AW-1:0]   buf_rd;
    logic [XLEN-1:0] buf_data;

    logic            buf_valid_d;
    logic [AW-1:0]   buf_rd_d;
    logic [XLEN-1:0] buf_data_d;

    src_e            src;
    logic            alu_hs;
    logic            ld_bad;
    logic [XLEN-1:0] ld_ext;

    logic            wr_en_d;
    logic [AW-1:0]   wr_addr_d;
    logic [XLEN-1:0] wr_data_d;
    logic            err_d;

    logic [NREG-1:0] busy_set;
    logic [NREG-1:0] busy_clr;
    logic [NREG-1:0] busy_d;

    function automatic logic [XLEN-1:0] ld_extend(
        input logic [XLEN-1:0] raw,
        input logic [2:0]      funct3,
        input logic [1:0]      addr_lo
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (addr_lo)
            2'd0:    b = raw[7:0];
            2'd1:    b = raw[15:8];
            2'd2:    b = raw[23:16];
            default: b = raw[31:24];
        endcase
        h = addr_lo[1] ? raw[31:16] : raw[15:0];
        case (funct3)
            3'b000:  ld_extend = {{(XLEN-8){b[7]}}, b};
            3'b100:  ld_extend = {{(XLEN-8){1'b0}}, b};
            3'b001:  ld_extend = {{(XLEN-16){h[15]}}, h};
            3'b101:  ld_extend = {{(XLEN-16){1'b0}}, h};
            3'b010:  ld_extend = raw;
            default: ld_extend = '0;
        endcase
    endfunction

    // Ready depends only on registered state
    assign o_alu_ready = !buf_valid;
    assign alu_hs      = i_alu_valid && !buf_valid;

    always_comb begin
        ld_ext = ld_extend(i_ld_raw, i_ld_funct3, i_ld_addr_lo);
        case (i_ld_funct3)
            3'b011, 3'b110, 3'b111: ld_bad = 1'b1;
            3'b001, 3'b101:         ld_bad = i_ld_addr_lo[0];
            3'b010:                 ld_bad = (i_ld_addr_lo != 2'd0);
            default:                ld_bad = 1'b0;
        endcase
    end

    // Write-port arbitration: load > buffered ALU > new ALU handshake
    always_comb begin
        src         = SRC_NONE;
        wr_en_d     = 1'b0;
        wr_addr_d   = o_rd_addr;
        wr_data_d   = o_rd_data;
        err_d       = 1'b0;
        buf_valid_d = buf_valid;
        buf_rd_d    = buf_rd;
        buf_data_d  = buf_data;

        if (i_ld_valid) begin
            src = SRC_LD;
        end else if (buf_valid) begin
            src = SRC_BUF;
        end else if (alu_hs) begin
            src = SRC_ALU;
        end

        case (src)
            SRC_LD: begin
                err_d = ld_bad;
                if (!ld_bad && (i_ld_rd != '0)) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = i_ld_rd;
                    wr_data_d = ld_ext;
                end
                // ALU handshake alongside a load parks in the buffer
                if (alu_hs) begin
                    buf_valid_d = 1'b1;
                    buf_rd_d    = i_alu_rd;
                    buf_data_d  = i_alu_data;
                end
            end
            SRC_BUF: begin
                buf_valid_d = 1'b0;
                if (buf_rd != '0) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = buf_rd;
                    wr_data_d = buf_data;
                end
            end
            SRC_ALU: begin
                if (i_alu_rd != '0) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = i_alu_rd;
                    wr_data_d = i_alu_data;
                end
            end
            default: ;
        endcase
    end

    // Pending-load scoreboard; a set in the same cycle as a clear wins
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (i_ld_issue && (i_ld_issue_rd != '0)) begin
            busy_set[i_ld_issue_rd] = 1'b1;
        end
        if (i_ld_valid) begin
            busy_clr[i_ld_rd] = 1'b1;
        end
        busy_d    = (o_busy & ~busy_clr) | busy_set;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_addr <= '0;
            o_rd_wren <= 1'b0;
            o_rd_data <= '0;
            o_busy    <= '0;
            o_ld_err  <= 1'b0;
            buf_valid <= 1'b0;
            buf_rd    <= '0;
            buf_data  <= '0;
        end else begin
            o_rd_addr <= wr_addr_d;
            o_rd_wren <= wr_en_d;
            o_rd_data <= wr_data_d;
            o_busy    <= busy_d;
            o_ld_err  <= err_d;
            buf_valid <= buf_valid_d;
            buf_rd    <= buf_rd_d;
            buf_data  <= buf_data_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
module tb_regfile_wb_ctrl;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_raw;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic [4:0]  rd_addr;
    logic        rd_wren;
    logic [31:0] rd_data;
    logic [31:0] busy;
    logic        ld_err;

    regfile_wb_ctrl #(.XLEN(32), .AW(5)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_alu_valid   (alu_valid),
        .o_alu_ready   (alu_ready),
        .i_alu_rd      (alu_rd),
        .i_alu_data    (alu_data),
        .i_ld_valid    (ld_valid),
        .i_ld_rd       (ld_rd),
        .i_ld_raw      (ld_raw),
        .i_ld_funct3   (ld_funct3),
        .i_ld_addr_lo  (ld_addr_lo),
        .i_ld_issue    (ld_issue),
        .i_ld_issue_rd (ld_issue_rd),
        .o_rd_addr     (rd_addr),
        .o_rd_wren     (rd_wren),
        .o_rd_data     (rd_data),
        .o_busy        (busy),
        .o_ld_err      (ld_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];

    task automatic exp_wr(input logic [4:0] rd, input logic [31:0] data, input int lat);
        exp_t e;
        e.is_err = 1'b0; e.rd = rd; e.data = data; e.cyc = cyc + lat;
        q.push_back(e);
    endtask

    task automatic exp_err(input int lat);
        exp_t e;
        e.is_err = 1'b1; e.rd = '0; e.data = '0; e.cyc = cyc + lat;
        q.push_back(e);
    endtask

    // Monitor: every write or error pulse must match the head of the queue
    always @(negedge clk) begin
        if (rst_n && (rd_wren || ld_err)) begin
            n_vec++;
            if (q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_output cyc=%0d wren=%0b err=%0b addr=%0d data=%h, required none",
                         cyc, rd_wren, ld_err, rd_addr, rd_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.is_err) begin
                    if (!(ld_err && !rd_wren && cyc == e.cyc)) begin
                        n_miss++;
                        $display("FAIL ld_err_pulse got err=%0b wren=%0b cyc=%0d, required err=1 wren=0 cyc=%0d",
                                 ld_err, rd_wren, cyc, e.cyc);
                    end
                end else begin
                    if (!(rd_wren && !ld_err && rd_addr == e.rd && rd_data == e.data && cyc == e.cyc)) begin
                        n_miss++;
                        $display("FAIL rd_write got wren=%0b err=%0b rd=%0d data=%h cyc=%0d, required wren=1 rd=%0d data=%h cyc=%0d",
                                 rd_wren, ld_err, rd_addr, rd_data, cyc, e.rd, e.data, e.cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s got %h, required %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_raw = '0; ld_funct3 = '0; ld_addr_lo = '0;
        ld_issue = 1'b0; ld_issue_rd = '0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] data);
        alu_valid = 1'b1; alu_rd = rd; alu_data = data;
    endtask

    task automatic ld(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] raw);
        ld_valid = 1'b1; ld_rd = rd; ld_funct3 = f3; ld_addr_lo = lo; ld_raw = raw;
    endtask

    task automatic issue(input logic [4:0] rd);
        ld_issue = 1'b1; ld_issue_rd = rd;
    endtask

    localparam logic [31:0] RAW = 32'h80FF_7F81;

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (3) step();
        chk("reset_busy",  busy, 32'h0);
        chk("reset_wren",  {31'b0, rd_wren}, 32'h0);
        chk("reset_err",   {31'b0, ld_err}, 32'h0);
        chk("reset_ready", {31'b0, alu_ready}, 32'h1);
        chk("reset_addr",  {27'b0, rd_addr}, 32'h0);
        chk("reset_data",  rd_data, 32'h0);
        rst_n = 1'b1;
        step();

        // ALU stream, one result per cycle
        for (int i = 0; i < 4; i++) begin
            alu(5'(i + 1), 32'h10 + 32'(i));
            chk("stream_ready", {31'b0, alu_ready}, 32'h1);
            exp_wr(5'(i + 1), 32'h10 + 32'(i), 1);
            step();
        end
        idle();
        step();

        // ALU + load collision
        alu(5'd5, 32'hAAAA_0000);
        ld(5'd6, 3'b010, 2'd0, 32'h1234_5678);
        chk("coll_ready_pre", {31'b0, alu_ready}, 32'h1);
        exp_wr(5'd6, 32'h1234_5678, 1);
        exp_wr(5'd5, 32'hAAAA_0000, 2);
        step();
        idle();
        chk("coll_ready_full", {31'b0, alu_ready}, 32'h0);
        step();
        chk("coll_ready_back", {31'b0, alu_ready}, 32'h1);
        step();

        // Load extension, back to back
        ld(5'd10, 3'b000, 2'd0, RAW); exp_wr(5'd10, 32'hFFFF_FF81, 1); step();
        ld(5'd11, 3'b100, 2'd3, RAW); exp_wr(5'd11, 32'h0000_0080, 1); step();
        ld(5'd12, 3'b001, 2'd2, RAW); exp_wr(5'd12, 32'hFFFF_80FF, 1); step();
        ld(5'd13, 3'b101, 2'd0, RAW); exp_wr(5'd13, 32'h0000_7F81, 1); step();
        ld(5'd18, 3'b000, 2'd1, RAW); exp_wr(5'd18, 32'h0000_007F, 1); step();
        ld(5'd20, 3'b100, 2'd2, RAW); exp_wr(5'd20, 32'h0000_00FF, 1); step();
        idle();
        step();

        // Load errors
        issue(5'd14); step(); idle();
        chk("err_busy_set", busy, 32'h0000_4000);
        ld(5'd14, 3'b001, 2'd1, RAW); exp_err(1); step(); idle();
        chk("err_busy_clr", busy, 32'h0);
        ld(5'd15, 3'b011, 2'd0, RAW); exp_err(1); step();
        ld(5'd19, 3'b010, 2'd2, RAW); exp_err(1); step(); idle();
        alu(5'd16, 32'h0000_0055);
        ld(5'd17, 3'b110, 2'd0, RAW);
        exp_err(1);
        exp_wr(5'd16, 32'h0000_0055, 2);
        step();
        idle();
        chk("err_slot_ready", {31'b0, alu_ready}, 32'h0);
        step();
        step();

        // rd == 0 from both sources
        alu(5'd0, 32'hDEAD_BEEF);
        chk("rd0_ready", {31'b0, alu_ready}, 32'h1);
        step(); idle();
        chk("rd0_not_buffered", {31'b0, alu_ready}, 32'h1);
        ld(5'd0, 3'b010, 2'd0, 32'hCAFE_F00D); step(); idle();
        alu(5'd1, 32'h0000_0077); exp_wr(5'd1, 32'h0000_0077, 1); step(); idle();
        step();

        // Scoreboard
        issue(5'd7); step(); idle();
        chk("sb_issue7", busy, 32'h0000_0080);
        issue(5'd9); step(); idle();
        chk("sb_issue9", busy, 32'h0000_0280);
        issue(5'd9); ld(5'd9, 3'b010, 2'd0, 32'h0000_0099);
        exp_wr(5'd9, 32'h0000_0099, 1);
        step(); idle();
        chk("sb_set_wins", busy, 32'h0000_0280);
        ld(5'd7, 3'b010, 2'd0, 32'h0000_0777); exp_wr(5'd7, 32'h0000_0777, 1); step(); idle();
        chk("sb_clr7", busy, 32'h0000_0200);
        alu(5'd9, 32'h0000_1234); exp_wr(5'd9, 32'h0000_1234, 1); step(); idle();
        chk("sb_alu_no_touch", busy, 32'h0000_0200);
        issue(5'd0); step(); idle();
        chk("sb_issue0", busy, 32'h0000_0200);
        ld(5'd9, 3'b010, 2'd0, 32'h0000_0999); exp_wr(5'd9, 32'h0000_0999, 1); step(); idle();
        chk("sb_clr9", busy, 32'h0);
        step();

        // Reset mid-operation: buffer full, busy = 0x4
        issue(5'd2); step(); idle();
        alu(5'd3, 32'h0000_0033);
        ld(5'd0, 3'b010, 2'd0, 32'h0000_0011);
        step(); idle();
        chk("mid_ready_full", {31'b0, alu_ready}, 32'h0);
        chk("mid_busy", busy, 32'h0000_0004);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  busy, 32'h0);
        chk("mid_rst_wren",  {31'b0, rd_wren}, 32'h0);
        chk("mid_rst_ready", {31'b0, alu_ready}, 32'h1);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_wren", {31'b0, rd_wren}, 32'h0);
        end

        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
Writeback-side controller that drives the single write port of the integer register file (rd address, write enable, write data). It merges two result sources: ALU results on a valid/ready channel and load responses from the LSU on a valid-only channel. Load data is byte/half-aligned and sign- or zero-extended here. A pending-load scoreboard tells decode which destination registers still await load data.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
AW, 5, register address width (2**AW registers; x0 hardwired zero).

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset
i_alu_valid  in  1  ALU result valid
o_alu_ready  out  1  ALU result accepted when valid&ready
i_alu_rd  in  AW  ALU destination register
i_alu_data  in  XLEN  ALU result
i_ld_valid  in  1  load response valid; always accepted, no backpressure
i_ld_rd  in  AW  load destination register
i_ld_raw  in  XLEN  raw aligned memory word
i_ld_funct3  in  3  load type (RV32I funct3)
i_ld_addr_lo  in  2  byte address bits [1:0]
i_ld_issue  in  1  decode issued a load this cycle
i_ld_issue_rd  in  AW  destination of issued load
o_rd_addr  out  AW  regfile write address
o_rd_wren  out  1  regfile write enable
o_rd_data  out  XLEN  regfile write data
o_busy  out  2**AW  per-register pending-load mask
o_ld_err  out  1  one-cycle pulse on illegal or misaligned load response

Behaviour:
- Reset: i_rst_n, asynchronous, active-low; clock i_clk. Reset clears o_rd_addr, o_rd_wren, o_rd_data, o_busy, o_ld_err and the holding buffer valid to 0. Any in-flight result is dropped.
- All outputs except o_alu_ready are registered. o_alu_ready = !buf_valid, with no combinational path from any i_* signal.
- Write-port arbitration selects at most one write per cycle, in this priority:
  1. i_ld_valid
  2. buffered ALU result (buf_valid)
  3. new ALU handshake
- An ALU handshake in a cycle where a load is also valid goes into the 1-entry holding buffer (buf_valid<=1).
- The buffer drains in the first cycle with no load. Handshakes never stall behind the buffer, because ready is low while it is full.
- Latency: the selected source appears on o_rd_* at the next rising edge; 1 cycle. With no loads the ALU path sustains 1 result/cycle.
- o_rd_wren is a one-cycle pulse per write and is 0 in cycles with no selected source. o_rd_addr/o_rd_data hold their last value when wren=0.
- rd==0 from either source: the handshake completes and arbitration slot is consumed, but o_rd_wren=0.
- Load extension, selected by i_ld_funct3:
  - 000 LB: byte at addr_lo, sign-extended.
  - 100 LBU: byte at addr_lo, zero-extended.
  - 001 LH: half at addr_lo[1], sign-extended.
  - 101 LHU: half at addr_lo[1], zero-extended.
  - 010 LW: full word.
- Load error: funct3 011/110/111, halfword with addr_lo[0]=1, or word with addr_lo!=0. On error: o_ld_err=1 for one cycle, o_rd_wren=0, and the busy bit of i_ld_rd is still cleared. The slot is consumed, so the buffered ALU result waits.
- Scoreboard:
  - i_ld_issue with i_ld_issue_rd!=0 sets the busy bit at the next edge.
  - i_ld_valid clears the bit of i_ld_rd at the next edge.
  - Same rd set and cleared in one cycle: set wins.
  - o_busy[0] is always 0.
  - ALU writes never alter o_busy.
  - Decode guarantees at most one outstanding load per rd.

Test Plan:
- Reset mid-operation: buffer full and o_busy=0x0000_0004; assert i_rst_n=0 -> o_busy=0, o_rd_wren=0, o_alu_ready=1 immediately; no write after release.
- ALU stream: 4 back-to-back results (rd=1..4, data=0x10..0x13) with no loads -> o_alu_ready stays 1; o_rd_wren=1 on 4 consecutive cycles, each write 1 cycle after its handshake, in order.
- Collision: ALU (rd=5, 0xAAAA_0000) and load (rd=6, LW, 0x1234_5678) in the same cycle -> cycle+1 writes rd6=0x1234_5678 and o_alu_ready=0; cycle+2 writes rd5=0xAAAA_0000 and ready returns to 1.
- Extension with i_ld_raw=0x80FF_7F81:
  - LB at addr_lo=0 -> 0xFFFF_FF81
  - LBU at addr_lo=3 -> 0x0000_0080
  - LH at addr_lo=2 -> 0xFFFF_80FF
  - LHU at addr_lo=0 -> 0x0000_7F81
- Errors: LH with addr_lo=1, and funct3=011 -> o_ld_err pulses, o_rd_wren=0, busy bit cleared. ALU result with rd=0 -> handshake completes, o_rd_wren=0.
- Scoreboard: issue rd=7 -> o_busy[7]=1 next cycle. Same cycle: issue rd=9 plus response rd=9 when bit 9 already set -> bit 9 stays 1. Response rd=7 -> bit 7=0. Issue rd=0 -> o_busy unchanged.
